lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives the data-memory port (en/wr/addr/wdata/wstrb/rdata) from the pipeline's memory stage.
- Accepts one load or store per valid/ready handshake.
- Generates the word-aligned address, byte strobes and lane-shifted write data.
- Fires the memory port for exactly one cycle per access, because the memory is combinational with side-effecting writes.
- Returns the extracted, sign- or zero-extended load data through a response handshake.

Parameters:
- WAIT_CYCLES, 0, extra idle cycles inserted between request accept and the memory strobe (latency modelling); 0..15
- ADDR_W, 32, byte-address width; data width fixed at 32

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  controller can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response available
- resp_ready  in  1  pipeline accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned access (only with the optional feature)
- mem_en  out  1  memory enable, one-cycle pulse
- mem_wr  out  1  memory write
- mem_addr  out  32  word-aligned address, {addr[ADDR_W-1:2],2'b00} zero-extended
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte strobes
- mem_rdata  in  32  combinational read data, valid in the same cycle as mem_en

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP. Reset state is IDLE.
- Reset values: req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_en=0; mem_wr=0; mem_addr=0; mem_wdata=0; mem_wstrb=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch wr/addr/size/unsigned/wdata.
  - Go to WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT:
  - 4-bit counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - Counter==0 -> ACCESS.
- ACCESS:
  - Exactly one cycle. mem_en=1, mem_wr=latched wr; mem_addr, mem_wstrb and mem_wdata are driven from registers.
  - Loads capture mem_rdata at the rising edge ending ACCESS. Then -> RESP.
  - mem_en is 0 in every other state; mem_wstrb=0 when mem_en=0.
- Strobes, off = addr[1:0]:
  - byte: 4'b0001<<off.
  - half: 4'b0011<<{off[1],1'b0}.
  - word: 4'b1111.
  - Loads drive mem_wstrb=0.
- Write data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Read data:
  - byte lane = rdata>>(8*off), half lane = rdata>>(16*off[1]).
  - Sign-extend unless req_unsigned. Word loads are passed through unchanged.
- RESP:
  - resp_valid=1; outputs stay stable until resp_ready.
  - On resp_ready, return to IDLE; req_ready rises the next cycle. No request/response overlap, at most one outstanding access.
  - resp_valid && resp_ready in the same cycle as a new req_valid: the new request is not accepted that cycle.
- Latency: accept -> resp_valid = WAIT_CYCLES+2 cycles.
- Reset mid-operation: immediate return to IDLE with reset values; an aborted access issues no further mem_en.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, skips WAIT/ACCESS and goes IDLE -> RESP next cycle.
  - resp_err=1, resp_rdata=0, mem_en never asserted.
- Undefined:
  - resp_err tied 0.
  - Offending low address bits are ignored: half uses off[1] only, word uses off=0.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2.
  - state enum (IDLE, WAIT, ACCESS, RESP).
  - strobe/lane helper functions.
- Sub-module lsu_align, purely combinational:
  - store path: size+off+wdata -> wstrb, wdata.
  - load path: size+off+unsigned+rdata -> extended rdata.
  - The FSM, counter and registers stay in lsu_mem_ctrl.

Test Plan:
- Store byte 0xAB to 0x80000003 -> one mem_en pulse; mem_addr=0x80000000, mem_wstrb=4'b1000, mem_wdata=0xABABABAB; resp_valid 2 cycles after accept, resp_rdata=0.
- Load half signed from 0x80000002, mem_rdata=0x8001_1234 -> resp_rdata=0xFFFF8001; same access unsigned -> 0x00008001.
- Load byte from off=1 with mem_rdata=0x00007F00 -> resp_rdata=0x0000007F; word load passes 0xDEADBEEF unchanged.
- WAIT_CYCLES=3 -> mem_en asserted exactly 4 cycles after accept, response at cycle 5; hold resp_ready=0 for 6 cycles -> resp_valid and resp_rdata stable, no extra mem_en.
- Drop rst_n during WAIT -> all outputs at reset values asynchronously, no mem_en pulse; back-to-back requests after reset each produce exactly one mem_en.
- With LSU_MISALIGN_CHECK_EN: word load from 0x80000002 -> resp_err=1, resp_rdata=0, mem_en never asserted; without the macro: mem_addr=0x80000000, resp_err=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM state type and byte-lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  // Size code 3 is illegal and falls through to word behaviour everywhere.
  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    lane_strobe = 4'b0001 << off;
      SZ_H:    lane_strobe = 4'b0011 << {off[1], 1'b0};
      SZ_W:    lane_strobe = 4'b1111;
      default: lane_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    lane_replicate = {4{data[7:0]}};
      SZ_H:    lane_replicate = {2{data[15:0]}};
      default: lane_replicate = data;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] off,
                                               input logic is_unsigned, input logic [31:0] data);
    logic signed [7:0]  byte_lane;
    logic signed [15:0] half_lane;
    byte_lane = 8'(data >> {off, 3'b000});
    half_lane = 16'(data >> {off[1], 4'b0000});
    case (size)
      SZ_B:    lane_extract = is_unsigned ? {24'h0, byte_lane} : 32'(byte_lane);
      SZ_H:    lane_extract = is_unsigned ? {16'h0, half_lane} : 32'(half_lane);
      default: lane_extract = data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment: store strobes/replicated data and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  strobe,
  output logic [31:0] lane_data,
  output logic [31:0] load_ext
);

  assign strobe    = lane_strobe(size, off);
  assign lane_data = lane_replicate(size, store_data);
  assign load_ext  = lane_extract(size, off, is_unsigned, load_data);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one single-cycle strobe on a combinational memory per accepted request.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
);

  state_t            state, state_next;
  logic [3:0]        wait_cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              misaligned;
  logic              accept;
  logic              access;
  logic [3:0]        strobe;
  logic [31:0]       lane_wdata;
  logic [31:0]       load_ext;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                      ((req_size[1] == 1'b1) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)           state_next = RESP;
          else if (WAIT_CYCLES > 0) state_next = WAIT;
          else                      state_next = ACCESS;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) state_next = ACCESS;
      end
      ACCESS: begin
        access     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = req_ready && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Request latch, wait countdown and load-data capture at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        wr_q     <= req_wr;
        addr_q   <= req_addr;
        size_q   <= req_size;
        uns_q    <= req_unsigned;
        wdata_q  <= req_wdata;
        err_q    <= misaligned;
        rdata_q  <= 32'h0;
        wait_cnt <= 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end else if (access && !wr_q) begin
        rdata_q  <= load_ext;
      end
    end
  end

  lsu_align u_align (
    .size        (size_q),
    .off         (addr_q[1:0]),
    .is_unsigned (uns_q),
    .store_data  (wdata_q),
    .load_data   (mem_rdata),
    .strobe      (strobe),
    .lane_data   (lane_wdata),
    .load_ext    (load_ext)
  );

  assign mem_en     = access;
  assign mem_wr     = access && wr_q;
  assign mem_addr   = 32'({addr_q[ADDR_W-1:2], 2'b00});
  assign mem_wdata  = lane_wdata;
  assign mem_wstrb  = (access && wr_q) ? strobe : 4'b0000;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
